// File: rtl/bram_dp_param_pkg.sv
// Shared constants and types for the parametrised true-dual-port RAM.
// Holds default geometry and the clear-sequencer state encoding.
package bram_dp_param_pkg;

  localparam int unsigned BRAM_DEF_DATA_W = 32;
  localparam int unsigned BRAM_DEF_ADDR_W = 10;
  localparam int unsigned BRAM_BYTE_W     = 8;

  typedef enum logic {
    BRAM_ST_INIT = 1'b0,
    BRAM_ST_RUN  = 1'b1
  } bram_state_e;

endpackage

// File: rtl/bram_dp_fwd_merge.sv
// Per-byte read-data merge for one RAM port.
// Ports:
//   raw        registered BRAM read word (pre-write contents)
//   own_wen    same-port write enables captured with the read
//   own_wdata  same-port write data captured with the read
//   oth_wen    other-port write enables (zero unless addresses matched)
//   oth_wdata  other-port write data
//   merged_c   forwarded read word (combinational)
// OTH_WINS selects which writer owns a lane both ports wrote.
module bram_dp_fwd_merge
  import bram_dp_param_pkg::*;
#(
  parameter int unsigned DATA_W   = BRAM_DEF_DATA_W,
  parameter int unsigned BYTE_W   = BRAM_BYTE_W,
  parameter bit          OTH_WINS = 1'b0,
  localparam int unsigned NBYTE   = DATA_W / BYTE_W
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [NBYTE-1:0]  own_wen,
  input  logic [DATA_W-1:0] own_wdata,
  input  logic [NBYTE-1:0]  oth_wen,
  input  logic [DATA_W-1:0] oth_wdata,
  output logic [DATA_W-1:0] merged_c
);

  // Later assignment in each branch is the higher-priority writer.
  always_comb begin
    merged_c = raw;
    for (int b = 0; b < int'(NBYTE); b++) begin
      if (OTH_WINS) begin
        if (own_wen[b]) merged_c[b*BYTE_W +: BYTE_W] = own_wdata[b*BYTE_W +: BYTE_W];
        if (oth_wen[b]) merged_c[b*BYTE_W +: BYTE_W] = oth_wdata[b*BYTE_W +: BYTE_W];
      end else begin
        if (oth_wen[b]) merged_c[b*BYTE_W +: BYTE_W] = oth_wdata[b*BYTE_W +: BYTE_W];
        if (own_wen[b]) merged_c[b*BYTE_W +: BYTE_W] = own_wdata[b*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/bram_dp_param.sv
// Parametrised true-dual-port RAM with byte write enables, cross-port
// write forwarding and a post-reset clear sequencer.
// Ports:
//   clk, resetn              clock, async active-low reset
//   init_done                RAM accepts traffic
//   addrN/rdenN/wenN/wdataN  port N request (N = 0, 1)
//   rdataN/rvalidN           port N read response
// Define BRAM_DP_OUTREG_EN to add an output register stage (latency 2).
module bram_dp_param
  import bram_dp_param_pkg::*;
#(
  parameter int unsigned DATA_W         = BRAM_DEF_DATA_W,
  parameter int unsigned ADDR_W         = BRAM_DEF_ADDR_W,
  parameter int unsigned BYTE_W         = BRAM_BYTE_W,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned NBYTE         = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              init_done,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              rden0,
  input  logic [NBYTE-1:0]  wen0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              rden1,
  input  logic [NBYTE-1:0]  wen1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  bram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q;

  logic [ADDR_W-1:0] wr_addr0_c;
  logic [NBYTE-1:0]  wr_wen0_c, wr_wen1_c;
  logic [DATA_W-1:0] wr_data0_c;
  logic              rd0_c, rd1_c, same_c;

  logic [DATA_W-1:0] raw0_q, raw1_q;
  logic [NBYTE-1:0]  own0_wen_q, oth0_wen_q, own1_wen_q, oth1_wen_q;
  logic [DATA_W-1:0] own0_wdata_q, oth0_wdata_q, own1_wdata_q, oth1_wdata_q;
  logic              rv0_q, rv1_q;
  logic [DATA_W-1:0] merged0_c, merged1_c;

  // Sequencer state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= CLEAR_ON_RESET ? BRAM_ST_INIT : BRAM_ST_RUN;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == BRAM_ST_RUN);
    end
  end

  // Next state and effective write/read controls; INIT owns port 0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_addr0_c = addr0;
    wr_wen0_c  = '0;
    wr_data0_c = wdata0;
    wr_wen1_c  = '0;
    rd0_c      = 1'b0;
    rd1_c      = 1'b0;
    same_c     = (addr0 == addr1);
    if (state_q == BRAM_ST_INIT) begin
      wr_addr0_c = cnt_q;
      wr_wen0_c  = '1;
      wr_data0_c = '0;
      cnt_d      = ADDR_W'(cnt_q + 1'b1);
      if (cnt_q == '1) begin
        state_d = BRAM_ST_RUN;
        cnt_d   = '0;
      end
    end else begin
      wr_wen0_c = wen0;
      wr_wen1_c = wen1;
      rd0_c     = rden0;
      rd1_c     = rden1;
    end
  end

  // Byte-lane writes; port 1 is applied last so it wins shared lanes.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(NBYTE); b++) begin
      if (wr_wen0_c[b]) mem[wr_addr0_c][b*BYTE_W +: BYTE_W] <= wr_data0_c[b*BYTE_W +: BYTE_W];
      if (wr_wen1_c[b]) mem[addr1][b*BYTE_W +: BYTE_W] <= wdata1[b*BYTE_W +: BYTE_W];
    end
  end

  // Read-first BRAM output plus write snapshots, loaded only on a read so
  // the merged result holds between reads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rv0_q        <= 1'b0;
      rv1_q        <= 1'b0;
      raw0_q       <= '0;
      raw1_q       <= '0;
      own0_wen_q   <= '0;
      oth0_wen_q   <= '0;
      own1_wen_q   <= '0;
      oth1_wen_q   <= '0;
      own0_wdata_q <= '0;
      oth0_wdata_q <= '0;
      own1_wdata_q <= '0;
      oth1_wdata_q <= '0;
    end else begin
      rv0_q <= rd0_c;
      rv1_q <= rd1_c;
      if (rd0_c) begin
        raw0_q       <= mem[addr0];
        own0_wen_q   <= wen0;
        own0_wdata_q <= wdata0;
        oth0_wen_q   <= same_c ? wen1 : '0;
        oth0_wdata_q <= wdata1;
      end
      if (rd1_c) begin
        raw1_q       <= mem[addr1];
        own1_wen_q   <= wen1;
        own1_wdata_q <= wdata1;
        oth1_wen_q   <= same_c ? wen0 : '0;
        oth1_wdata_q <= wdata0;
      end
    end
  end

  bram_dp_fwd_merge #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .OTH_WINS(1'b1)) u_merge0 (
    .raw       (raw0_q),
    .own_wen   (own0_wen_q),
    .own_wdata (own0_wdata_q),
    .oth_wen   (oth0_wen_q),
    .oth_wdata (oth0_wdata_q),
    .merged_c  (merged0_c)
  );

  bram_dp_fwd_merge #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .OTH_WINS(1'b0)) u_merge1 (
    .raw       (raw1_q),
    .own_wen   (own1_wen_q),
    .own_wdata (own1_wdata_q),
    .oth_wen   (oth1_wen_q),
    .oth_wdata (oth1_wdata_q),
    .merged_c  (merged1_c)
  );

  assign init_done = init_done_q;

`ifdef BRAM_DP_OUTREG_EN
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              rvalid0_q, rvalid1_q;

  // Output stage registers the already-forwarded word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= rv0_q;
      rvalid1_q <= rv1_q;
      if (rv0_q) rdata0_q <= merged0_c;
      if (rv1_q) rdata1_q <= merged1_c;
    end
  end

  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
`else
  assign rdata0  = merged0_c;
  assign rdata1  = merged1_c;
  assign rvalid0 = rv0_q;
  assign rvalid1 = rv1_q;
`endif

endmodule

// File: tb/tb_bram_dp_param.sv
// Scoreboard bench for bram_dp_param (ADDR_W=4, 32-bit words, clear on reset).
// Read expectations come from a byte-lane memory model and are queued per
// port with their due cycle; a monitor pops them when rvalid fires.
module tb_bram_dp_param;

`ifdef BRAM_DP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        init_done;
  logic [3:0]  addr0 = '0, addr1 = '0;
  logic        rden0 = 1'b0, rden1 = 1'b0;
  logic [3:0]  wen0 = '0, wen1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          run_m = 1'b0;
  logic [31:0] mem_m [16];
  logic [31:0] last0 = '0, last1 = '0;
  exp_t        q0[$];
  exp_t        q1[$];

  bram_dp_param #(
    .DATA_W(32), .ADDR_W(4), .BYTE_W(8), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .resetn(resetn), .init_done(init_done),
    .addr0(addr0), .rden0(rden0), .wen0(wen0), .wdata0(wdata0),
    .rdata0(rdata0), .rvalid0(rvalid0),
    .addr1(addr1), .rden1(rden1), .wen1(wen1), .wdata1(wdata1),
    .rdata1(rdata1), .rvalid1(rvalid1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] apply(input logic [31:0] old, input logic [3:0] w,
                                        input logic [31:0] d);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (w[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rden0 = 1'b0; rden1 = 1'b0; wen0 = '0; wen1 = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
  endtask

  // One request cycle on both ports; expectations use pre-edge model state.
  task automatic drive(input logic [3:0] a0, input logic r0, input logic [3:0] w0,
                       input logic [31:0] d0, input logic [3:0] a1, input logic r1,
                       input logic [3:0] w1, input logic [31:0] d1);
    exp_t        e;
    logic [31:0] v;
    addr0 = a0; rden0 = r0; wen0 = w0; wdata0 = d0;
    addr1 = a1; rden1 = r1; wen1 = w1; wdata1 = d1;
    if (run_m) begin
      if (r0) begin
        v = apply(mem_m[a0], w0, d0);
        if (a0 == a1) v = apply(v, w1, d1);
        e.data = v; e.due = cyc + LAT;
        q0.push_back(e);
      end
      if (r1) begin
        v = mem_m[a1];
        if (a0 == a1) v = apply(v, w0, d0);
        v = apply(v, w1, d1);
        e.data = v; e.due = cyc + LAT;
        q1.push_back(e);
      end
      mem_m[a0] = apply(mem_m[a0], w0, d0);
      mem_m[a1] = apply(mem_m[a1], w1, d1);
    end
    idle_cycle();
    set_idle();
  endtask

  task automatic count_init(input string tag);
    int n = 0;
    while (!init_done && n < 100) begin
      idle_cycle();
      n++;
    end
    check(tag, 32'(n), 32'd16);
  endtask

  task automatic reset_now();
    resetn = 1'b0;
    run_m  = 1'b0;
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
  endtask

  // Response monitor: pops expectations, checks latency, hold and stray pulses.
  always @(posedge clk) begin
    exp_t e0, e1;
    #1;
    if (rvalid0) begin
      if (q0.size() == 0) check("rv0_unexpected", 32'(rvalid0), 32'd0);
      else begin
        e0 = q0.pop_front();
        check("rd0_data", rdata0, e0.data);
        check("rd0_latency", 32'(cyc), 32'(e0.due));
      end
      last0 = rdata0;
    end else begin
      if (q0.size() != 0 && q0[0].due <= cyc) begin
        check("rv0_missing", 32'(rvalid0), 32'd1);
        void'(q0.pop_front());
      end
      check("rd0_hold", rdata0, last0);
    end
    if (rvalid1) begin
      if (q1.size() == 0) check("rv1_unexpected", 32'(rvalid1), 32'd0);
      else begin
        e1 = q1.pop_front();
        check("rd1_data", rdata1, e1.data);
        check("rd1_latency", 32'(cyc), 32'(e1.due));
      end
      last1 = rdata1;
    end else begin
      if (q1.size() != 0 && q1[0].due <= cyc) begin
        check("rv1_missing", 32'(rvalid1), 32'd1);
        void'(q1.pop_front());
      end
      check("rd1_hold", rdata1, last1);
    end
  end

  initial begin
    logic [3:0] ra, rb, rw0, rw1;
    #1;
    reset_now();
    repeat (3) idle_cycle();
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);

    // Release with a write and a read pending through INIT; both must be ignored.
    resetn = 1'b1;
    addr0 = 4'd2; wen0 = 4'hF; wdata0 = 32'hFFFF_FFFF;
    addr1 = 4'd2; rden1 = 1'b1;
    count_init("init_cycles");
    set_idle();
    clear_model();
    run_m = 1'b1;

    // Every word reads back zero, from both ports.
    for (int i = 0; i < 16; i++) drive(4'(i), 1'b1, 4'h0, 32'h0, 4'(15 - i), 1'b1, 4'h0, 32'h0);

    // Write on port 0, read next cycle on port 1.
    drive(4'd5, 1'b0, 4'hF, 32'hDEAD_BEEF, 4'd0, 1'b0, 4'h0, 32'h0);
    drive(4'd0, 1'b0, 4'h0, 32'h0, 4'd5, 1'b1, 4'h0, 32'h0);

    // Port 1 partial write forwarded into a same-cycle port 0 read.
    drive(4'd0, 1'b0, 4'h0, 32'h0, 4'd9, 1'b0, 4'hF, 32'h1122_3344);
    drive(4'd9, 1'b1, 4'h0, 32'h0, 4'd9, 1'b0, 4'h5, 32'hAABB_CCDD);
    drive(4'd9, 1'b1, 4'h0, 32'h0, 4'd9, 1'b1, 4'h0, 32'h0);

    // Dual write same address: port 1 owns shared lanes, both ports reading.
    drive(4'd3, 1'b1, 4'hF, 32'h0101_0101, 4'd3, 1'b1, 4'h3, 32'h0000_FFFF);
    drive(4'd3, 1'b1, 4'h0, 32'h0, 4'd3, 1'b0, 4'h0, 32'h0);

    // Port 0 write forwarded into port 1 read; port 1 own write-first.
    drive(4'd7, 1'b0, 4'hC, 32'hCAFE_0000, 4'd7, 1'b1, 4'h0, 32'h0);
    drive(4'd7, 1'b1, 4'h3, 32'h0000_1234, 4'd8, 1'b1, 4'h6, 32'h0055_6600);
    drive(4'd7, 1'b0, 4'h0, 32'h0, 4'd8, 1'b1, 4'h0, 32'h0);

    // Randomised traffic with frequent address collisions.
    for (int i = 0; i < 150; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom_range(0, 15));
      rw0 = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
      rw1 = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
      drive(ra, 1'($urandom), rw0, $urandom, rb, 1'($urandom), rw1, $urandom);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end
    drive(4'd5, 1'b0, 4'hF, 32'h5A5A_A5A5, 4'd0, 1'b0, 4'h0, 32'h0);
    repeat (4) idle_cycle();
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    // Read in flight when reset hits: any later pulse is flagged as stray.
    drive(4'd5, 1'b1, 4'h0, 32'h0, 4'd0, 1'b0, 4'h0, 32'h0);
    #1;
    reset_now();
    #2;
    check("drop_rvalid0", 32'(rvalid0), 32'd0);
    check("drop_rdata0", rdata0, 32'd0);
    repeat (2) idle_cycle();

    // Reset again at cnt=7 of the clear sequence; clear restarts from zero.
    resetn = 1'b1;
    repeat (7) idle_cycle();
    check("midinit_done", 32'(init_done), 32'd0);
    addr0 = 4'd3; rden0 = 1'b1;
    #1;
    reset_now();
    #2;
    check("midinit_rvalid0", 32'(rvalid0), 32'd0);
    set_idle();
    repeat (2) idle_cycle();
    resetn = 1'b1;
    count_init("reinit_cycles");
    clear_model();
    run_m = 1'b1;

    for (int i = 0; i < 16; i++) drive(4'(i), 1'b1, 4'h0, 32'h0, 4'(i ^ 5), 1'b1, 4'h0, 32'h0);
    repeat (4) idle_cycle();
    check("q0_final", 32'(q0.size()), 32'd0);
    check("q1_final", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
